stream_rr_arbiter: RTL

- Shares one valid/ready stream sink between `N_REQ` upstream producers.
- Arbitration is packet-level round-robin; a grant is held from the first beat of a packet to its `last` beat.
- A single registered output stage drives the downstream custom logic block.
- Sits between the requester sources and the existing `down_*` datapath; exports an 8-bit debug vector for the board visualiser.

---
 rtl/stream_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 31 +++
 rtl/stream_rr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the packet-level round-robin stream arbiter.
package stream_arb_pkg;

    // ARB picks a new owner each beat; LOCKED holds the owner until its last beat.
    typedef enum logic {ARB, LOCKED} arb_state_t;

    // Bit positions inside the 8-bit debug vector for the board visualiser.
    localparam int DBG_UP_ANY     = 0;
    localparam int DBG_GRANT_LO   = 1;
    localparam int DBG_GRANT_HI   = 2;
    localparam int DBG_DOWN_LAST  = 3;
    localparam int DBG_DOWN_READY = 4;
    localparam int DBG_DOWN_VALID = 5;
    localparam int DBG_STATE      = 6;
    localparam int DBG_SPARE      = 7;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate the request vector so the
// search starts just after ptr, then take the first set request.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 gnt_any
);

    localparam int IDX_W = $clog2(N);

    logic [N-1:0] rot;

    // Rotate so rot[0] is the requester after ptr, then priority-encode the lowest set bit.
    always_comb begin
        rot     = '0;
        gnt_idx = '0;
        gnt_any = |req;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[(int'(ptr) + 1 + k) % N];
        end
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_idx = IDX_W'((int'(ptr) + 1 + k) % N);
            end
        end
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Shares one valid/ready sink between N_REQ producers with packet-level
// round-robin arbitration and a single registered output stage.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int D_WIDTH = 6,
    parameter int N_REQ   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ*D_WIDTH-1:0]   up_data,
    input  logic [N_REQ-1:0]           up_last,
    input  logic [N_REQ-1:0]           up_valid,
    output logic [N_REQ-1:0]           up_ready,
    output logic [D_WIDTH-1:0]         down_data,
    output logic                       down_last,
    output logic [$clog2(N_REQ)-1:0]   down_src,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [7:0]                 debug
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

    logic [D_WIDTH-1:0] data_q;
    logic               last_q;
    logic [IDX_W-1:0]   src_q;
    logic               valid_q;

    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   grant_idx;
    logic               granted;
    logic               load_en;
    logic               accept;
    logic [D_WIDTH-1:0] sel_data;
    logic               sel_last;
    logic               sel_valid;

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .req    (up_valid),
        .ptr    (ptr_q),
        .gnt_idx(pick_idx),
        .gnt_any(pick_any)
    );

    // Choose the owner of this cycle and steer its beat toward the output register.
    always_comb begin
        load_en   = !valid_q || down_ready;
        granted   = (state_q == LOCKED) ? 1'b1 : pick_any;
        grant_idx = (state_q == LOCKED) ? lock_idx_q : pick_idx;
        up_ready  = '0;
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                up_ready[i] = granted && load_en && !rst;
                sel_data    = up_data[i*D_WIDTH +: D_WIDTH];
                sel_last    = up_last[i];
                sel_valid   = up_valid[i];
            end
        end
        accept = granted && load_en && !rst && sel_valid;
    end

    // Lock onto a requester after a non-last beat; release and advance ptr on its last beat.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        if (accept) begin
            if (sel_last) begin
                state_d = ARB;
                ptr_d   = grant_idx;
            end else if (state_q == ARB) begin
                state_d    = LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    // Arbitration state registers; ptr starts at the top so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB;
            ptr_q      <= IDX_W'(N_REQ - 1);
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Output stage: load on accept, clear valid on a drain with nothing to replace it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            src_q   <= '0;
            valid_q <= 1'b0;
        end else if (accept) begin
            data_q  <= sel_data;
            last_q  <= sel_last;
            src_q   <= grant_idx;
            valid_q <= 1'b1;
        end else if (valid_q && down_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign down_data  = data_q;
    assign down_last  = last_q;
    assign down_src   = src_q;
    assign down_valid = valid_q;

    // Pack the visualiser debug vector; the spare top bit reads as zero.
    always_comb begin
        debug                             = '0;
        debug[DBG_UP_ANY]                 = |up_valid;
        debug[DBG_GRANT_HI:DBG_GRANT_LO]  = 2'(grant_idx);
        debug[DBG_DOWN_LAST]              = last_q;
        debug[DBG_DOWN_READY]             = down_ready;
        debug[DBG_DOWN_VALID]             = valid_q;
        debug[DBG_STATE]                  = (state_q == LOCKED);
        debug[DBG_SPARE]                  = 1'b0;
    end

endmodule
